// File: rtl/mult_8x8_seq_ctrl_if.sv
// mult_8x8_seq_ctrl_if: operand/result handshake and shared 4x4 sub-multiplier port bundle
interface mult_8x8_seq_ctrl_if #(parameter int MODE_W = 2);
    logic                  in_valid;
    logic                  in_ready;
    logic [7:0]            A;
    logic [7:0]            B;
    logic [4*MODE_W-1:0]   quad_mode;
    logic [3:0]            sub_a;
    logic [3:0]            sub_b;
    logic [MODE_W-1:0]     sub_mode;
    logic                  sub_en;
    logic [7:0]            sub_p;
    logic                  out_valid;
    logic                  out_ready;
    logic [15:0]           R;
    logic                  busy;
    modport master (
        output in_valid, A, B, quad_mode, sub_p, out_ready,
        input  in_ready, sub_a, sub_b, sub_mode, sub_en, out_valid, R, busy
    );
    modport slave (
        input  in_valid, A, B, quad_mode, sub_p, out_ready,
        output in_ready, sub_a, sub_b, sub_mode, sub_en, out_valid, R, busy
    );
endinterface

// File: rtl/mult_8x8_seq_ctrl.sv
// mult_8x8_seq_ctrl: 8x8 product from four time-multiplexed 4x4 sub-products, valid/ready both sides
module mult_8x8_seq_ctrl #(
    parameter bit SKIP_ZERO = 1'b0,
    parameter int MODE_W    = 2
) (
    input logic clk,
    input logic rst_n,
    mult_8x8_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t              state_q;
    logic [7:0]          a_q, b_q;
    logic [4*MODE_W-1:0] mode_q;
    logic [15:0]         acc_q, acc_d, r_q;
    logic [1:0]          qcnt_q, qn;
    logic [3:0]          sub_a_q, sub_b_q, an, bn;
    logic [MODE_W-1:0]   sub_mode_q, mn;
    logic                sub_en_q, en_n, out_valid_q, accept;
    logic [3:0]          sh;
    function automatic logic [3:0] nib(input logic [7:0] v, input logic hi);
        return hi ? v[7:4] : v[3:0];
    endfunction
    assign bus.in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
    assign bus.busy      = state_q != IDLE;
    assign bus.sub_a     = sub_a_q;
    assign bus.sub_b     = sub_b_q;
    assign bus.sub_mode  = sub_mode_q;
    assign bus.sub_en    = sub_en_q;
    assign bus.out_valid = out_valid_q;
    assign bus.R         = r_q;
    // Next quadrant operands are registered one cycle ahead so sub_p lines up with the current quadrant
    always_comb begin
        accept = bus.in_valid & bus.in_ready;
        qn     = qcnt_q + 2'd1;
        an     = accept ? bus.A[3:0] : nib(a_q, qn[1]);
        bn     = accept ? bus.B[3:0] : nib(b_q, qn[0]);
        mn     = accept ? bus.quad_mode[MODE_W-1:0] : mode_q[qn*MODE_W +: MODE_W];
        en_n   = !(SKIP_ZERO && (an == 4'd0 || bn == 4'd0));
        sh     = qcnt_q == 2'd0 ? 4'd0 : qcnt_q == 2'd3 ? 4'd8 : 4'd4;
        acc_d  = acc_q + (sub_en_q ? ({8'd0, bus.sub_p} << sh) : 16'd0);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= '0;
            acc_q       <= '0;
            r_q         <= '0;
            qcnt_q      <= '0;
            sub_a_q     <= '0;
            sub_b_q     <= '0;
            sub_mode_q  <= '0;
            sub_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            state_q     <= CALC;
            a_q         <= bus.A;
            b_q         <= bus.B;
            mode_q      <= bus.quad_mode;
            acc_q       <= '0;
            qcnt_q      <= '0;
            sub_a_q     <= an;
            sub_b_q     <= bn;
            sub_mode_q  <= mn;
            sub_en_q    <= en_n;
            out_valid_q <= 1'b0;
        end else if (state_q == CALC) begin
            acc_q  <= acc_d;
            qcnt_q <= qn;
            if (qcnt_q == 2'd3) begin
                state_q     <= DONE;
                r_q         <= acc_d;
                out_valid_q <= 1'b1;
                sub_en_q    <= 1'b0;
            end else begin
                sub_a_q    <= an;
                sub_b_q    <= bn;
                sub_mode_q <= mn;
                sub_en_q   <= en_n;
            end
        end else if (state_q == DONE && bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// tb_mult_8x8_seq_ctrl: directed checks of the nibble sequencer with an exact 4x4 sub-multiplier model
module tb_mult_8x8_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt = 0;
    int   total = 0;
    mult_8x8_seq_ctrl_if #(.MODE_W(2)) ifc0 ();
    mult_8x8_seq_ctrl_if #(.MODE_W(2)) ifc1 ();
    mult_8x8_seq_ctrl #(.SKIP_ZERO(1'b0), .MODE_W(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0));
    mult_8x8_seq_ctrl #(.SKIP_ZERO(1'b1), .MODE_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));
    assign ifc0.sub_p = ifc0.sub_a * ifc0.sub_b;
    assign ifc1.sub_p = ifc1.sub_a * ifc1.sub_b;
    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task accept(input bit s, input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        if (s) begin
            ifc1.A = a; ifc1.B = b; ifc1.quad_mode = m; ifc1.in_valid = 1'b1;
            tick;
            ifc1.in_valid = 1'b0;
        end else begin
            ifc0.A = a; ifc0.B = b; ifc0.quad_mode = m; ifc0.in_valid = 1'b1;
            tick;
            ifc0.in_valid = 1'b0;
        end
    endtask

    task test_reset;
        repeat (3) tick;
        rst_n = 1'b1;
        #1;
        total++; if (ifc0.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", ifc0.in_ready); else pass_cnt++;
        total++; if (ifc0.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", ifc0.out_valid); else pass_cnt++;
        total++; if (ifc0.busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", ifc0.busy); else pass_cnt++;
        total++; if (ifc0.sub_en !== 1'b0) $display("FAIL rst_sub_en got %b exp 0", ifc0.sub_en); else pass_cnt++;
        total++; if (ifc0.R !== 16'h0) $display("FAIL rst_R got %h exp 0000", ifc0.R); else pass_cnt++;
        total++; if ({ifc0.sub_a, ifc0.sub_b, ifc0.sub_mode} !== 10'h0) $display("FAIL rst_sub got %h exp 000", {ifc0.sub_a, ifc0.sub_b, ifc0.sub_mode}); else pass_cnt++;
    endtask

    task test_full_ones;
        accept(1'b0, 8'hFF, 8'hFF, 8'h00);
        for (int i = 0; i < 4; i++) begin
            total++; if ({ifc0.sub_a, ifc0.sub_b, ifc0.sub_en} !== 9'b1111_1111_1) $display("FAIL ones_q%0d got a=%h b=%h en=%b exp a=f b=f en=1", i, ifc0.sub_a, ifc0.sub_b, ifc0.sub_en); else pass_cnt++;
            total++; if (ifc0.out_valid !== 1'b0) $display("FAIL ones_early_valid q%0d got %b exp 0", i, ifc0.out_valid); else pass_cnt++;
            tick;
        end
        total++; if (ifc0.out_valid !== 1'b1) $display("FAIL ones_valid got %b exp 1", ifc0.out_valid); else pass_cnt++;
        total++; if (ifc0.R !== 16'hFE01) $display("FAIL ones_R got %h exp fe01", ifc0.R); else pass_cnt++;
        total++; if (ifc0.sub_en !== 1'b0) $display("FAIL ones_done_en got %b exp 0", ifc0.sub_en); else pass_cnt++;
        ifc0.out_ready = 1'b1;
        tick;
        ifc0.out_ready = 1'b0;
        #1;
        total++; if (ifc0.out_valid !== 1'b0) $display("FAIL ones_drop_valid got %b exp 0", ifc0.out_valid); else pass_cnt++;
        total++; if (ifc0.R !== 16'hFE01) $display("FAIL ones_R_hold got %h exp fe01", ifc0.R); else pass_cnt++;
        total++; if (ifc0.in_ready !== 1'b1 || ifc0.busy !== 1'b0) $display("FAIL ones_idle got rdy=%b busy=%b exp rdy=1 busy=0", ifc0.in_ready, ifc0.busy); else pass_cnt++;
        total++; if ({ifc0.sub_a, ifc0.sub_b} !== 8'hFF) $display("FAIL ones_sub_hold got %h exp ff", {ifc0.sub_a, ifc0.sub_b}); else pass_cnt++;
    endtask

    task test_quad_modes;
        logic [3:0] ea [4];
        logic [3:0] eb [4];
        logic [1:0] em [4];
        ea = '{4'hC, 4'hC, 4'h3, 4'h3};
        eb = '{4'h5, 4'hA, 4'h5, 4'hA};
        em = '{2'd0, 2'd1, 2'd2, 2'd3};
        accept(1'b0, 8'h3C, 8'hA5, 8'hE4);
        for (int i = 0; i < 4; i++) begin
            total++; if ({ifc0.sub_a, ifc0.sub_b, ifc0.sub_mode} !== {ea[i], eb[i], em[i]}) $display("FAIL quad_q%0d got a=%h b=%h m=%0d exp a=%h b=%h m=%0d", i, ifc0.sub_a, ifc0.sub_b, ifc0.sub_mode, ea[i], eb[i], em[i]); else pass_cnt++;
            tick;
        end
        total++; if (ifc0.out_valid !== 1'b1 || ifc0.R !== 16'h26AC) $display("FAIL quad_R got v=%b R=%h exp v=1 R=26ac", ifc0.out_valid, ifc0.R); else pass_cnt++;
        ifc0.out_ready = 1'b1;
        tick;
        ifc0.out_ready = 1'b0;
    endtask

    task test_back_to_back;
        ifc0.out_ready = 1'b1;
        ifc0.A = 8'h12; ifc0.B = 8'h34; ifc0.quad_mode = 8'h00; ifc0.in_valid = 1'b1;
        tick;
        ifc0.A = 8'h0F; ifc0.B = 8'h10;
        repeat (3) tick;
        total++; if (ifc0.out_valid !== 1'b0) $display("FAIL b2b_early got %b exp 0", ifc0.out_valid); else pass_cnt++;
        tick;
        total++; if (ifc0.out_valid !== 1'b1 || ifc0.R !== 16'h03A8) $display("FAIL b2b_first got v=%b R=%h exp v=1 R=03a8", ifc0.out_valid, ifc0.R); else pass_cnt++;
        total++; if (ifc0.in_ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", ifc0.in_ready); else pass_cnt++;
        tick;
        total++; if (ifc0.out_valid !== 1'b0 || ifc0.busy !== 1'b1) $display("FAIL b2b_reissue got v=%b busy=%b exp v=0 busy=1", ifc0.out_valid, ifc0.busy); else pass_cnt++;
        total++; if ({ifc0.sub_a, ifc0.sub_b} !== 8'hF0) $display("FAIL b2b_q0 got %h exp f0", {ifc0.sub_a, ifc0.sub_b}); else pass_cnt++;
        repeat (3) tick;
        total++; if (ifc0.out_valid !== 1'b0) $display("FAIL b2b_early2 got %b exp 0", ifc0.out_valid); else pass_cnt++;
        ifc0.in_valid = 1'b0;
        tick;
        total++; if (ifc0.out_valid !== 1'b1 || ifc0.R !== 16'h00F0) $display("FAIL b2b_second got v=%b R=%h exp v=1 R=00f0", ifc0.out_valid, ifc0.R); else pass_cnt++;
        tick;
        ifc0.out_ready = 1'b0;
        #1;
        total++; if (ifc0.busy !== 1'b0 || ifc0.out_valid !== 1'b0) $display("FAIL b2b_idle got busy=%b v=%b exp 0 0", ifc0.busy, ifc0.out_valid); else pass_cnt++;
    endtask

    task test_stall;
        accept(1'b0, 8'h05, 8'h07, 8'h00);
        repeat (4) tick;
        ifc0.A = 8'hFF; ifc0.B = 8'hFF; ifc0.in_valid = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            total++; if (ifc0.out_valid !== 1'b1 || ifc0.R !== 16'h0023) $display("FAIL stall_hold c%0d got v=%b R=%h exp v=1 R=0023", i, ifc0.out_valid, ifc0.R); else pass_cnt++;
            total++; if (ifc0.in_ready !== 1'b0 || ifc0.busy !== 1'b1) $display("FAIL stall_ready c%0d got rdy=%b busy=%b exp rdy=0 busy=1", i, ifc0.in_ready, ifc0.busy); else pass_cnt++;
            tick;
        end
        ifc0.out_ready = 1'b1;
        #1;
        total++; if (ifc0.in_ready !== 1'b1) $display("FAIL stall_release_ready got %b exp 1", ifc0.in_ready); else pass_cnt++;
        tick;
        ifc0.in_valid = 1'b0;
        ifc0.out_ready = 1'b0;
        total++; if (ifc0.out_valid !== 1'b0 || ifc0.busy !== 1'b1 || ifc0.sub_en !== 1'b1) $display("FAIL stall_accept got v=%b busy=%b en=%b exp 0 1 1", ifc0.out_valid, ifc0.busy, ifc0.sub_en); else pass_cnt++;
        repeat (4) tick;
        total++; if (ifc0.out_valid !== 1'b1 || ifc0.R !== 16'hFE01) $display("FAIL stall_result got v=%b R=%h exp v=1 R=fe01", ifc0.out_valid, ifc0.R); else pass_cnt++;
        ifc0.out_ready = 1'b1;
        tick;
        ifc0.out_ready = 1'b0;
    endtask

    task test_skip_zero;
        logic ee [4];
        ee = '{1'b0, 1'b1, 1'b0, 1'b0};
        accept(1'b1, 8'h0F, 8'hF0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            total++; if (ifc1.sub_en !== ee[i] || ifc1.out_valid !== 1'b0) $display("FAIL skip_q%0d got en=%b v=%b exp en=%b v=0", i, ifc1.sub_en, ifc1.out_valid, ee[i]); else pass_cnt++;
            tick;
        end
        total++; if (ifc1.out_valid !== 1'b1 || ifc1.R !== 16'h0E10) $display("FAIL skip_R got v=%b R=%h exp v=1 R=0e10", ifc1.out_valid, ifc1.R); else pass_cnt++;
        ifc1.out_ready = 1'b1;
        tick;
        ifc1.out_ready = 1'b0;
    endtask

    task test_reset_abort;
        accept(1'b0, 8'hFF, 8'hFF, 8'hE4);
        repeat (2) tick;
        total++; if ({ifc0.sub_a, ifc0.sub_b, ifc0.sub_mode} !== 10'b1111_1111_10) $display("FAIL abort_q2 got a=%h b=%h m=%0d exp f f 2", ifc0.sub_a, ifc0.sub_b, ifc0.sub_mode); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({ifc0.out_valid, ifc0.sub_en, ifc0.busy} !== 3'b000) $display("FAIL abort_ctrl got v/en/busy=%b exp 000", {ifc0.out_valid, ifc0.sub_en, ifc0.busy}); else pass_cnt++;
        total++; if ({ifc0.R, ifc0.sub_a, ifc0.sub_b, ifc0.sub_mode} !== 26'h0) $display("FAIL abort_data got R=%h a=%h b=%h m=%0d exp all 0", ifc0.R, ifc0.sub_a, ifc0.sub_b, ifc0.sub_mode); else pass_cnt++;
        tick;
        rst_n = 1'b1;
        #1;
        total++; if (ifc0.in_ready !== 1'b1) $display("FAIL abort_ready got %b exp 1", ifc0.in_ready); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            total++; if (ifc0.out_valid !== 1'b0) $display("FAIL abort_stale c%0d got %b exp 0", i, ifc0.out_valid); else pass_cnt++;
            tick;
        end
        accept(1'b0, 8'h02, 8'h03, 8'h00);
        repeat (4) tick;
        total++; if (ifc0.out_valid !== 1'b1 || ifc0.R !== 16'h0006) $display("FAIL abort_next got v=%b R=%h exp v=1 R=0006", ifc0.out_valid, ifc0.R); else pass_cnt++;
    endtask

    initial begin
        ifc0.in_valid = 1'b0; ifc0.out_ready = 1'b0; ifc0.A = '0; ifc0.B = '0; ifc0.quad_mode = '0;
        ifc1.in_valid = 1'b0; ifc1.out_ready = 1'b0; ifc1.A = '0; ifc1.B = '0; ifc1.quad_mode = '0;
        test_reset;
        test_full_ones;
        test_quad_modes;
        test_back_to_back;
        test_stall;
        test_skip_zero;
        test_reset_abort;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
